clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Button-driven controller sequencing the digital clock core's load and alarm inputs.
- Takes three debounced single-cycle button pulses plus the core's Alarm flag.
- Lets the user edit HH:MM in BCD, then asserts the core's H_in/M_in, LD_time, LD_alarm, STOP_al and AL_ON with hold times long enough for the core's divided 1 s tick to sample.

Parameters:
- LD_HOLD, 12: cycles LD_time / LD_alarm / STOP_al stay high; must exceed the core tick period (10 clk).
- TIMEOUT, 1000: idle cycles in an edit state before abandoning the edit.
- TO_W, 10: width of the timeout counter; 2^TO_W must exceed TIMEOUT.

Ports:
- clk  in  1  system clock, same clock as the clock core
- reset  in  1  asynchronous, active-low reset
- btn_mode  in  1  one-cycle pulse: mode / stop alarm
- btn_next  in  1  one-cycle pulse: next field / commit
- btn_inc  in  1  one-cycle pulse: increment field
- btn_al  in  1  one-cycle pulse: toggle alarm enable
- alarm_active  in  1  core Alarm output
- H_in1  out  2  hour tens, BCD 0-2
- H_in0  out  4  hour units, BCD 0-9
- M_in1  out  4  minute tens, BCD 0-5
- M_in0  out  4  minute units, BCD 0-9
- LD_time  out  1  load time to core
- LD_alarm  out  1  load alarm to core
- STOP_al  out  1  stop ringing alarm
- AL_ON  out  1  alarm enable level
- edit_sel  out  2  0 none, 1 hour, 2 minute (display blink)
- edit_alarm  out  1  1 while in SET_AL_* / LOAD_AL

Behaviour:
- Reset (reset=0, async):
  - State RUN; edit hour=00, minute=00.
  - All outputs 0; hold counter and timeout counter = 0.
- Button priority in a cycle: btn_mode > btn_next > btn_inc; at most one action per cycle. btn_al is handled independently.
- H_in1/H_in0/M_in1/M_in0 continuously drive the edit registers, which stay stable throughout every LOAD state.
- States and transitions:
  - RUN:
    - btn_mode with alarm_active=1 -> STOP_al=1 for LD_HOLD cycles; remain in RUN.
    - btn_mode with alarm_active=0 -> SET_TIME_H.
    - btn_al toggles AL_ON.
    - While STOP_al is high, btn_mode is ignored; btn_al is still honoured.
  - SET_TIME_H (edit_sel=1): btn_inc -> hour+1; btn_next -> SET_TIME_M; btn_mode -> SET_AL_H, no load.
  - SET_TIME_M (edit_sel=2): btn_inc -> minute+1; btn_next -> LOAD_TIME; btn_mode -> SET_AL_H, no load.
  - LOAD_TIME: LD_time=1 for exactly LD_HOLD cycles, then RUN. All buttons ignored.
  - SET_AL_H / SET_AL_M: same as the time states with edit_alarm=1.
    - btn_next from SET_AL_M -> LOAD_AL.
    - btn_mode in either -> RUN, no load.
  - LOAD_AL: LD_alarm=1 for LD_HOLD cycles, then RUN. AL_ON is unchanged.
- Hold timing:
  - LD_* / STOP_al rise the cycle after the triggering state entry or button.
  - They fall after LD_HOLD high cycles.
  - LD_time and LD_alarm are never high together.
- Increment arithmetic (BCD, no binary intermediate):
  - Hour: 09->10, 19->20, 23->00. Hour tens never exceeds 2; units never exceed 3 when tens=2.
  - Minute: x9 -> (x+1)0; 59->00. No carry into hour.
- Timeout:
  - The counter clears on state entry and on any button pulse.
  - In any SET_* state, reaching TIMEOUT idle cycles -> RUN with no load.
  - Edit values are retained for the next entry.
- Edit values persist across modes: entering SET_AL_H shows the last edited time, not the current core time.
- Reset mid-LOAD: all strobes drop immediately. On release, start in RUN with edit registers cleared.
- alarm_active changes outside RUN are ignored. AL_ON is held.

Test Plan:
1. Reset low then high; check RUN, all outputs 0. Then btn_mode, btn_inc x3, btn_next, btn_inc x2, btn_next -> LD_time high 12 cycles with H_in=03, M_in=02; then RUN, edit_sel=0.
2. Hour increment from 22, 3 pulses -> 23, 00, 01. Minute increment from 58, 2 pulses -> 59, 00, with hour unchanged. Check 09->10 and 19->20.
3. Alarm path: btn_mode, then btn_mode (enter SET_AL_H, edit_alarm=1), set 07:30, btn_next x2 -> LD_alarm high 12 cycles, LD_time stays 0. btn_al in RUN -> AL_ON=1.
4. alarm_active=1 in RUN, btn_mode -> STOP_al high 12 cycles, state stays RUN. Second btn_mode during the hold is ignored.
5. Enter SET_TIME_M, idle 1000 cycles -> RUN, no LD pulse. Re-enter: edit values retained.
6. btn_mode+btn_next+btn_inc in the same cycle in SET_TIME_H -> only SET_AL_H, hour unchanged. Reset low during LOAD_TIME -> LD_time=0 in the same cycle.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven editor for the clock core's time and alarm.
// The user edits HH:MM in BCD; loads and alarm stops are held long enough
// for the core's slow tick to sample them.
module clock_set_ctrl #(
  parameter int LD_HOLD = 12,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_al,
  input  logic       alarm_active,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] edit_sel,
  output logic       edit_alarm
);

  localparam int HOLD_W = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;

  typedef enum logic [2:0] {
    S_RUN, S_SET_TIME_H, S_SET_TIME_M, S_LOAD_TIME,
    S_SET_AL_H, S_SET_AL_M, S_LOAD_AL
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_h1;
  logic [3:0]        r_h0, r_m1, r_m0;
  logic [HOLD_W-1:0] r_hold;
  logic [TO_W-1:0]   r_to;
  logic              r_ld_time, r_ld_alarm, r_stop_al, r_al_on;

  logic              w_any_btn, w_in_set, w_in_load, w_hold_last, w_to_expire;
  logic              w_inc_h, w_inc_m, w_stop_start;
  logic [1:0]        w_h1_inc;
  logic [3:0]        w_h0_inc, w_m1_inc, w_m0_inc;

  assign w_any_btn   = btn_mode | btn_next | btn_inc | btn_al;
  assign w_in_set    = (r_state == S_SET_TIME_H) || (r_state == S_SET_TIME_M) ||
                       (r_state == S_SET_AL_H)   || (r_state == S_SET_AL_M);
  assign w_in_load   = (r_state == S_LOAD_TIME) || (r_state == S_LOAD_AL);
  assign w_hold_last = (r_hold == HOLD_W'(LD_HOLD - 1));
  assign w_to_expire = w_in_set && !w_any_btn && (r_to == TO_W'(TIMEOUT - 1));

  // BCD successors of the edit registers; hours wrap 23->00, minutes 59->00
  always_comb begin
    w_h1_inc = r_h1;
    w_h0_inc = r_h0 + 4'd1;
    if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
      w_h1_inc = 2'd0;
      w_h0_inc = 4'd0;
    end else if (r_h0 == 4'd9) begin
      w_h1_inc = r_h1 + 2'd1;
      w_h0_inc = 4'd0;
    end
    w_m1_inc = r_m1;
    w_m0_inc = r_m0 + 4'd1;
    if (r_m0 == 4'd9) begin
      w_m0_inc = 4'd0;
      w_m1_inc = (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-cycle actions; mode beats next beats inc
  always_comb begin
    w_state_nxt  = r_state;
    w_inc_h      = 1'b0;
    w_inc_m      = 1'b0;
    w_stop_start = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (btn_mode && !r_stop_al) begin
          if (alarm_active) w_stop_start = 1'b1;
          else              w_state_nxt  = S_SET_TIME_H;
        end
      end
      S_SET_TIME_H, S_SET_AL_H: begin
        if (btn_mode)
          w_state_nxt = (r_state == S_SET_TIME_H) ? S_SET_AL_H : S_RUN;
        else if (btn_next)
          w_state_nxt = (r_state == S_SET_TIME_H) ? S_SET_TIME_M : S_SET_AL_M;
        else if (btn_inc)
          w_inc_h = 1'b1;
        else if (w_to_expire)
          w_state_nxt = S_RUN;
      end
      S_SET_TIME_M, S_SET_AL_M: begin
        if (btn_mode)
          w_state_nxt = (r_state == S_SET_TIME_M) ? S_SET_AL_H : S_RUN;
        else if (btn_next)
          w_state_nxt = (r_state == S_SET_TIME_M) ? S_LOAD_TIME : S_LOAD_AL;
        else if (btn_inc)
          w_inc_m = 1'b1;
        else if (w_to_expire)
          w_state_nxt = S_RUN;
      end
      S_LOAD_TIME, S_LOAD_AL: begin
        if (w_hold_last) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Edit registers: only touched by increments, kept across modes and timeouts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h1 <= 2'd0;
      r_h0 <= 4'd0;
      r_m1 <= 4'd0;
      r_m0 <= 4'd0;
    end else begin
      if (w_inc_h) begin
        r_h1 <= w_h1_inc;
        r_h0 <= w_h0_inc;
      end
      if (w_inc_m) begin
        r_m1 <= w_m1_inc;
        r_m0 <= w_m0_inc;
      end
    end
  end

  // Shared hold counter: loads and alarm-stop never overlap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     r_hold <= '0;
    else if ((w_in_load || r_stop_al) && !w_hold_last) r_hold <= r_hold + 1'b1;
    else                                            r_hold <= '0;
  end

  // Idle timeout counter for the edit states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              r_to <= '0;
    else if (!w_in_set || w_any_btn || w_state_nxt != r_state) r_to <= '0;
    else                                                     r_to <= r_to + 1'b1;
  end

  // Registered strobes: rise with the load-state entry / stop button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
      r_stop_al  <= 1'b0;
    end else begin
      r_ld_time  <= (w_state_nxt == S_LOAD_TIME);
      r_ld_alarm <= (w_state_nxt == S_LOAD_AL);
      if (w_stop_start)                r_stop_al <= 1'b1;
      else if (r_stop_al && w_hold_last) r_stop_al <= 1'b0;
    end
  end

  // Alarm enable toggles outside the load states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         r_al_on <= 1'b0;
    else if (btn_al && !w_in_load)      r_al_on <= ~r_al_on;
  end

  assign H_in1      = r_h1;
  assign H_in0      = r_h0;
  assign M_in1      = r_m1;
  assign M_in0      = r_m0;
  assign LD_time    = r_ld_time;
  assign LD_alarm   = r_ld_alarm;
  assign STOP_al    = r_stop_al;
  assign AL_ON      = r_al_on;
  assign edit_sel   = (r_state == S_SET_TIME_H || r_state == S_SET_AL_H) ? 2'd1 :
                      (r_state == S_SET_TIME_M || r_state == S_SET_AL_M) ? 2'd2 : 2'd0;
  assign edit_alarm = (r_state == S_SET_AL_H) || (r_state == S_SET_AL_M) ||
                      (r_state == S_LOAD_AL);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed + random bench for clock_set_ctrl against a time-of-day model.
module tb_clock_set_ctrl;
  localparam int LD_HOLD = 12;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0, reset = 1'b0;
  logic       btn_mode = 0, btn_next = 0, btn_inc = 0, btn_al = 0, alarm_active = 0;
  logic [1:0] H_in1, edit_sel;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, edit_alarm;

  clock_set_ctrl #(.LD_HOLD(LD_HOLD), .TIMEOUT(TIMEOUT), .TO_W(10)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_next(btn_next),
    .btn_inc(btn_inc), .btn_al(btn_al), .alarm_active(alarm_active),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .edit_sel(edit_sel), .edit_alarm(edit_alarm));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Model: time as integers, editing as (field, alarm-target), strobes as countdowns
  int m_hr, m_mn, m_field, m_idle, m_ld_left, m_stop_left;
  bit m_edit, m_eal, m_ldal, m_alon;

  function automatic void model_reset();
    m_hr = 0; m_mn = 0; m_field = 0; m_idle = 0; m_ld_left = 0; m_stop_left = 0;
    m_edit = 0; m_eal = 0; m_ldal = 0; m_alon = 0;
  endfunction

  function automatic void model_step(bit m, bit n, bit i, bit a, bit alarm);
    if (m_ld_left > 0) begin
      m_ld_left--;
    end else if (!m_edit) begin
      if (a) m_alon = !m_alon;
      if (m && m_stop_left == 0) begin
        if (alarm) m_stop_left = LD_HOLD;
        else begin m_edit = 1; m_eal = 0; m_field = 1; m_idle = 0; end
      end else if (m_stop_left > 0) m_stop_left--;
    end else begin
      if (a) m_alon = !m_alon;
      if (m) begin
        if (!m_eal) begin m_eal = 1; m_field = 1; m_idle = 0; end
        else m_edit = 0;
      end else if (n) begin
        if (m_field == 1) begin m_field = 2; m_idle = 0; end
        else begin m_edit = 0; m_ld_left = LD_HOLD; m_ldal = m_eal; end
      end else if (i) begin
        if (m_field == 1) m_hr = (m_hr + 1) % 24; else m_mn = (m_mn + 1) % 60;
        m_idle = 0;
      end else if (a) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT) m_edit = 0;
      end
    end
  endfunction

  function automatic logic [20:0] model_vec();
    logic [1:0] sel;
    sel = m_edit ? 2'(m_field) : 2'd0;
    return {2'(m_hr / 10), 4'(m_hr % 10), 4'(m_mn / 10), 4'(m_mn % 10),
            (m_ld_left > 0) && !m_ldal, (m_ld_left > 0) && m_ldal, m_stop_left > 0,
            m_alon, sel, (m_edit && m_eal) || ((m_ld_left > 0) && m_ldal)};
  endfunction

  wire [20:0] dut_vec = {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al,
                         AL_ON, edit_sel, edit_alarm};
  wire [15:0] hm = {2'b00, H_in1, H_in0, M_in1, M_in0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given button pulses; full output compare afterwards
  task automatic step(input bit m, input bit n, input bit i, input bit a, input string tag);
    btn_mode = m; btn_next = n; btn_inc = i; btn_al = a;
    @(posedge clk);
    model_step(m, n, i, a, alarm_active);
    #1;
    btn_mode = 0; btn_next = 0; btn_inc = 0; btn_al = 0;
    check(tag, 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic idle(input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) step(0, 0, 0, 0, tag);
  endtask

  int hi;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", 32'(dut_vec), 32'd0);
    reset = 1'b1;

    // 1: set 03:02 and load time
    step(1, 0, 0, 0, "t1_enter");
    check("t1_edit_hour", 32'(edit_sel), 32'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, "t1_inc_h");
    step(0, 1, 0, 0, "t1_next");
    for (int k = 0; k < 2; k++) step(0, 0, 1, 0, "t1_inc_m");
    step(0, 1, 0, 0, "t1_load");
    check("t1_hm", 32'(hm), 32'h0302);
    hi = 1;
    for (int k = 0; k < LD_HOLD; k++) begin
      step(0, 0, 0, 0, "t1_hold");
      if (LD_time) hi++;
    end
    check("t1_ld_time_cycles", hi, LD_HOLD);
    check("t1_back_run", 32'(edit_sel), 32'd0);

    // 2: hour wrap and minute wrap (19 incs from 03 pass 09->10 and 19->20)
    step(1, 0, 0, 0, "t2_enter");
    for (int k = 0; k < 19; k++) begin
      step(0, 0, 1, 0, "t2_inc_h");
      if (k == 6)  check("t2_h_09_10", 32'(hm[15:8]), 32'h10);
      if (k == 16) check("t2_h_19_20", 32'(hm[15:8]), 32'h20);
    end
    check("t2_h22", 32'(hm[15:8]), 32'h22);
    step(0, 0, 1, 0, "t2_h"); check("t2_h23", 32'(hm[15:8]), 32'h23);
    step(0, 0, 1, 0, "t2_h"); check("t2_h00", 32'(hm[15:8]), 32'h00);
    step(0, 0, 1, 0, "t2_h"); check("t2_h01", 32'(hm[15:8]), 32'h01);
    step(0, 1, 0, 0, "t2_next");
    for (int k = 0; k < 56; k++) step(0, 0, 1, 0, "t2_inc_m");
    check("t2_m58", 32'(hm), 32'h0158);
    step(0, 0, 1, 0, "t2_m"); check("t2_m59", 32'(hm), 32'h0159);
    step(0, 0, 1, 0, "t2_m"); check("t2_m00_no_carry", 32'(hm), 32'h0100);
    step(1, 0, 0, 0, "t2_to_al");
    step(1, 0, 0, 0, "t2_to_run");

    // 3: alarm load 07:30, then enable alarm
    step(1, 0, 0, 0, "t3_enter");
    step(1, 0, 0, 0, "t3_al_h");
    check("t3_edit_alarm", 32'(edit_alarm), 32'd1);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, "t3_inc_h");
    step(0, 1, 0, 0, "t3_next");
    for (int k = 0; k < 30; k++) step(0, 0, 1, 0, "t3_inc_m");
    step(0, 1, 0, 0, "t3_load");
    check("t3_hm", 32'(hm), 32'h0730);
    hi = 1;
    for (int k = 0; k < LD_HOLD; k++) begin
      step(0, 0, 0, 0, "t3_hold");
      if (LD_alarm) hi++;
      if (LD_time)  hi += 100;
    end
    check("t3_ld_alarm_cycles", hi, LD_HOLD);
    step(0, 0, 0, 1, "t3_al");
    check("t3_al_on", 32'(AL_ON), 32'd1);

    // 4: stop a ringing alarm; second press during hold ignored
    alarm_active = 1;
    step(1, 0, 0, 0, "t4_stop");
    hi = 1;
    for (int k = 0; k < LD_HOLD + 2; k++) begin
      step(k == 3, 0, 0, 0, "t4_hold");
      if (STOP_al) hi++;
    end
    check("t4_stop_cycles", hi, LD_HOLD);
    check("t4_still_run", 32'(edit_sel), 32'd0);
    alarm_active = 0;

    // 5: idle timeout from SET_TIME_M keeps edit values
    step(1, 0, 0, 0, "t5_enter");
    step(0, 1, 0, 0, "t5_min");
    idle(TIMEOUT - 1, "t5_idle");
    check("t5_before_to", 32'(edit_sel), 32'd2);
    step(0, 0, 0, 0, "t5_to");
    check("t5_after_to", 32'(edit_sel), 32'd0);
    check("t5_no_load", 32'({LD_time, LD_alarm}), 32'd0);
    step(1, 0, 0, 0, "t5_reenter");
    check("t5_retained", 32'(hm), 32'h0730);

    // 6: simultaneous buttons -> mode only; reset mid-load
    step(1, 1, 1, 0, "t6_multi");
    check("t6_multi_sel", 32'({edit_sel, edit_alarm}), 32'b011);
    check("t6_hour_kept", 32'(hm), 32'h0730);
    step(1, 0, 0, 0, "t6_run");
    step(1, 0, 0, 0, "t6_enter");
    step(0, 1, 0, 0, "t6_next");
    step(0, 1, 0, 0, "t6_load");
    idle(3, "t6_hold");
    #2 reset = 1'b0;
    #1 check("t6_async_drop", 32'(LD_time), 32'd0);
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    check("t6_after_reset", 32'(dut_vec), 32'd0);

    // Random buttons and alarm flag against the model
    for (int k = 0; k < 3000; k++) begin
      alarm_active = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
